// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor built around one full-adder cell.
// It processes one bit per clock, LSB first, so each operation takes WIDTH cycles.
// The sum, c_out and overflow registers are written only when the last bit
// completes, so a consumer never sees a partial result.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last completed result
// RUN   | one operand bit processed per clock, LSB first
// DONE  | results valid, done pulse; a start here begins the next op
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_res;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;
    logic             s_bit;
    logic             carry_nxt;
    logic             load;
    logic             last_bit;

    // Full-adder cell on the current LSBs and the registered carry
    assign s_bit     = sh_a[0] ^ sh_b[0] ^ carry;
    assign carry_nxt = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
    assign last_bit  = (state == RUN) && (bit_cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs; start is only accepted outside RUN
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shift registers, running carry and bit counter.
    // Subtraction is a + ~b + 1, so the inverted operand and a forced carry
    // of 1 are loaded up front.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_a    <= '0;
            sh_b    <= '0;
            sh_res  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
        end else if (load) begin
            sh_a    <= a;
            sh_b    <= sub ? ~b : b;
            carry   <= sub ? 1'b1 : c_in;
            bit_cnt <= '0;
        end else if (state == RUN) begin
            sh_a    <= sh_a >> 1;
            sh_b    <= sh_b >> 1;
            sh_res  <= {s_bit, sh_res[WIDTH-1:1]};
            carry   <= carry_nxt;
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // Result registers update only on the edge that finishes the MSB.
    // On that edge the registered carry is the carry into the MSB, so
    // overflow can be formed directly from it and the new carry.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (last_bit) begin
            sum      <= {s_bit, sh_res[WIDTH-1:1]};
            c_out    <= carry_nxt;
            overflow <= carry ^ carry_nxt;
        end
    end

endmodule
